// File: rtl/ctrl_ram_if.sv
// rtl/ctrl_ram_if.sv - host and RAM-side signal bundle for the ctrl_ram sequencer
interface ctrl_ram_if #(
  parameter int W  = 32,
  parameter int AW = 5
);
  logic          Inicio;
  logic          Wh;
  logic [AW-1:0] DirH;
  logic [W-1:0]  DatoH;
  logic [W-1:0]  DatosS;
  logic [AW-1:0] DirRam;
  logic [W-1:0]  DatosE;
  logic          WE;
  logic          Ocupado;
  logic          Listo;

  modport master (
    input  Inicio, Wh, DirH, DatoH, DatosS,
    output DirRam, DatosE, WE, Ocupado, Listo
  );

  modport slave (
    output Inicio, Wh, DirH, DatoH, DatosS,
    input  DirRam, DatosE, WE, Ocupado, Listo
  );
endinterface

// File: rtl/ctrl_ram.sv
// rtl/ctrl_ram.sv - sole RAM driver: host write pass-through in IDLE, resta/suma/status/count sequence on start
module ctrl_ram #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic      clk,
  input  logic      rst,
  ctrl_ram_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, LA_R, LB_R, ES_R, LA_S, LB_S, ES_S, ES_F, ES_C, FIN
  } state_t;

  state_t        state, state_d;
  logic [W-1:0]  op_a, op_a_d, op_b, op_b_d;
  logic [W-1:0]  cuenta, cuenta_d;
  logic [3:0]    banderas, banderas_d;
  logic [AW-1:0] dir_d;
  logic [W-1:0]  datos_d;
  logic          we_d, ocupado_d, listo_d;
  logic [W-1:0]  resta;
  logic [W:0]    suma;

  // Outputs are registered, so results are formed from the live read data at the edge that leaves the second read.
  assign resta = op_a - bus.DatosS;
  assign suma  = {1'b0, op_a} + {1'b0, bus.DatosS};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      cuenta      <= '0;
      banderas    <= '0;
      bus.DirRam  <= '0;
      bus.DatosE  <= '0;
      bus.WE      <= 1'b0;
      bus.Ocupado <= 1'b0;
      bus.Listo   <= 1'b0;
    end else begin
      state       <= state_d;
      op_a        <= op_a_d;
      op_b        <= op_b_d;
      cuenta      <= cuenta_d;
      banderas    <= banderas_d;
      bus.DirRam  <= dir_d;
      bus.DatosE  <= datos_d;
      bus.WE      <= we_d;
      bus.Ocupado <= ocupado_d;
      bus.Listo   <= listo_d;
    end
  end

  always_comb begin
    state_d    = state;
    op_a_d     = op_a;
    op_b_d     = op_b;
    cuenta_d   = cuenta;
    banderas_d = banderas;
    dir_d      = bus.DirRam;
    datos_d    = bus.DatosE;
    we_d       = 1'b0;
    ocupado_d  = 1'b0;
    listo_d    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Inicio) begin
          state_d    = LA_R;
          dir_d      = AW'(0);
          ocupado_d  = 1'b1;
          banderas_d = '0;
        end else begin
          dir_d   = bus.DirH;
          datos_d = bus.DatoH;
          we_d    = bus.Wh;
        end
      end
      LA_R: begin
        state_d   = LB_R;
        op_a_d    = bus.DatosS;
        dir_d     = AW'(1);
        ocupado_d = 1'b1;
      end
      LB_R: begin
        state_d       = ES_R;
        op_b_d        = bus.DatosS;
        dir_d         = AW'(2);
        datos_d       = resta;
        we_d          = 1'b1;
        ocupado_d     = 1'b1;
        banderas_d[0] = op_a < bus.DatosS;
        banderas_d[1] = (op_a[W-1] != bus.DatosS[W-1]) && (resta[W-1] != op_a[W-1]);
      end
      ES_R: begin
        state_d   = LA_S;
        dir_d     = AW'(3);
        ocupado_d = 1'b1;
      end
      LA_S: begin
        state_d   = LB_S;
        op_a_d    = bus.DatosS;
        dir_d     = AW'(4);
        ocupado_d = 1'b1;
      end
      LB_S: begin
        state_d       = ES_S;
        op_b_d        = bus.DatosS;
        dir_d         = AW'(5);
        datos_d       = suma[W-1:0];
        we_d          = 1'b1;
        ocupado_d     = 1'b1;
        banderas_d[2] = suma[W];
        banderas_d[3] = (op_a[W-1] == bus.DatosS[W-1]) && (suma[W-1] != op_a[W-1]);
      end
      ES_S: begin
        state_d   = ES_F;
        dir_d     = AW'(6);
        datos_d   = {{(W-4){1'b0}}, banderas};
        we_d      = 1'b1;
        ocupado_d = 1'b1;
      end
      ES_F: begin
        state_d   = ES_C;
        cuenta_d  = cuenta + 1'b1;
        dir_d     = AW'(7);
        datos_d   = cuenta + 1'b1;
        we_d      = 1'b1;
        ocupado_d = 1'b1;
      end
      ES_C: begin
        state_d = FIN;
        listo_d = 1'b1;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_ctrl_ram.sv
// tb/tb_ctrl_ram.sv - randomized self-checking bench for ctrl_ram with a behavioural RAM and result model
module tb_ctrl_ram;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] ram     [32];
  logic [31:0] ref_mem [32];
  logic [31:0] ref_cnt;

  ctrl_ram_if #(.W(32), .AW(5)) bus ();

  ctrl_ram #(.W(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.WE) ram[bus.DirRam] <= bus.DatosE;
  assign bus.DatosS = ram[bus.DirRam];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_flags(input logic [31:0] a, b, c, d);
    longint sd, ss, us;
    sd = longint'($signed(a)) - longint'($signed(b));
    ss = longint'($signed(c)) + longint'($signed(d));
    us = longint'({32'h0, c}) + longint'({32'h0, d});
    return {28'h0, (ss > MAXS || ss < MINS), (us > 64'sh0FFFF_FFFF),
            (sd > MAXS || sd < MINS), (a < b)};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic host_write(input logic [4:0] a, input logic [31:0] d);
    bus.Wh = 1'b1; bus.DirH = a; bus.DatoH = d;
    tick();
    bus.Wh = 1'b0;
    @(negedge clk);
    check("hw_we", 32'(bus.WE), 32'd1);
    check("hw_dir", 32'(bus.DirRam), 32'(a));
    check("hw_data", bus.DatosE, d);
    ref_mem[a] = d;
    tick();
  endtask

  task automatic compare_mem();
    for (int i = 0; i < 32; i++) check($sformatf("mem%0d", i), ram[i], ref_mem[i]);
  endtask

  // Entered just after the edge that sampled Inicio; returns just after the edge ending cycle 10.
  task automatic run_body();
    logic [31:0] e_diff, e_sum, e_flags, e_cnt;
    e_diff  = ref_mem[0] - ref_mem[1];
    e_sum   = ref_mem[3] + ref_mem[4];
    e_flags = model_flags(ref_mem[0], ref_mem[1], ref_mem[3], ref_mem[4]);
    e_cnt   = ref_cnt + 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("we_c%0d", k), 32'(bus.WE), 32'(k == 3 || k == 6 || k == 7 || k == 8));
      check($sformatf("ocupado_c%0d", k), 32'(bus.Ocupado), 32'(k >= 1 && k <= 8));
      check($sformatf("listo_c%0d", k), 32'(bus.Listo), 32'(k == 9));
      if (k <= 8) check($sformatf("dir_c%0d", k), 32'(bus.DirRam), 32'(k - 1));
      if (k == 3) check("data_resta", bus.DatosE, e_diff);
      if (k == 6) check("data_suma", bus.DatosE, e_sum);
      if (k == 7) check("data_flags", bus.DatosE, e_flags);
      if (k == 8) check("data_count", bus.DatosE, e_cnt);
      tick();
      if (k <= 8) begin
        bus.Wh    = 1'($urandom_range(0, 1));
        bus.DirH  = 5'($urandom_range(0, 31));
        bus.DatoH = $urandom;
      end else begin
        bus.Wh = 1'b0;
      end
    end
    ref_mem[2] = e_diff;
    ref_mem[5] = e_sum;
    ref_mem[6] = e_flags;
    ref_mem[7] = e_cnt;
    ref_cnt    = e_cnt;
    compare_mem();
  endtask

  task automatic run_seq();
    bus.Inicio = 1'b1;
    tick();
    bus.Inicio = 1'b0;
    run_body();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ref_cnt = 0;
  endtask

  task automatic load4(input logic [31:0] a, b, c, d);
    host_write(5'd0, a);
    host_write(5'd1, b);
    host_write(5'd3, c);
    host_write(5'd4, d);
  endtask

  initial begin
    bus.Inicio = 1'b0; bus.Wh = 1'b0; bus.DirH = '0; bus.DatoH = '0;
    rst = 1'b1;
    ref_cnt = 0;
    tick();
    tick();
    @(negedge clk);
    check("rst_dir", 32'(bus.DirRam), 32'd0);
    check("rst_data", bus.DatosE, 32'd0);
    check("rst_we", 32'(bus.WE), 32'd0);
    check("rst_ocupado", 32'(bus.Ocupado), 32'd0);
    check("rst_listo", 32'(bus.Listo), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 32; i++) host_write(5'(i), $urandom);

    load4(32'd10, 32'd3, 32'd7, 32'd5);
    run_seq();
    check("t1_mem2", ram[2], 32'd7);
    check("t1_mem5", ram[5], 32'd12);
    check("t1_mem6", ram[6], 32'h0);
    check("t1_mem7", ram[7], 32'd1);

    load4(32'd3, 32'd10, 32'hFFFF_FFFF, 32'd1);
    run_seq();
    check("t2_mem2", ram[2], 32'hFFFF_FFF9);
    check("t2_mem5", ram[5], 32'h0);
    check("t2_mem6", ram[6], 32'h5);

    load4(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 32'd1);
    run_seq();
    check("t3_mem2", ram[2], 32'h7FFF_FFFF);
    check("t3_mem5", ram[5], 32'h8000_0000);
    check("t3_mem6", ram[6], 32'hA);

    bus.Inicio = 1'b1; bus.Wh = 1'b1; bus.DirH = 5'd3; bus.DatoH = 32'd99;
    tick();
    bus.Inicio = 1'b0; bus.Wh = 1'b0;
    run_body();
    check("start_wins_mem3", ram[3], 32'h7FFF_FFFF);

    for (int r = 0; r < 8; r++) begin
      load4(pick(), pick(), pick(), pick());
      host_write(5'($urandom_range(8, 31)), $urandom);
      run_seq();
    end

    bus.Inicio = 1'b1;
    tick();
    bus.Inicio = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_we", 32'(bus.WE), 32'd0);
    check("midrst_ocupado", 32'(bus.Ocupado), 32'd0);
    check("midrst_listo", 32'(bus.Listo), 32'd0);
    ref_mem[2] = ref_mem[0] - ref_mem[1];
    ref_cnt = 0;
    for (int i = 0; i < 4; i++) tick();
    compare_mem();
    run_seq();
    check("midrst_next_mem7", ram[7], 32'd1);

    do_reset();
    bus.Inicio = 1'b1;
    tick();
    run_body();
    check("held_mem7_first", ram[7], 32'd1);
    bus.Inicio = 1'b0;
    run_body();
    check("held_mem7_second", ram[7], 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
